// File: rtl/cache_arbiter_if.sv
// Bus bundle between the I-cache, the D-cache, the shared memory port and cache_arbiter.
// The slave modport is the arbiter's view. The master modport is the caches and memory side.
interface cache_arbiter_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  logic              last_grant;  // 0 = I-cache, 1 = D-cache; status only

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata,
    output last_grant
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata,
    input  last_grant
  );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates the single cacheline memory port between the I-cache fill path and the D-cache fill/writeback path.
// Tie-breaking: with ARB_ROUND_ROBIN_EN defined, a tie goes to the side that was not granted last. Otherwise D always wins a tie.
module cache_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_op_wr;
  logic              r_last_d;

  logic w_d_req;
  logic w_pick_d;
  logic w_grant_i;
  logic w_grant_d;
  logic w_mem_read;
  logic w_mem_write;
  logic w_i_resp;
  logic w_d_resp;

  assign w_d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_pick_d = ~r_last_d;
`else
  assign w_pick_d = 1'b1;
`endif

  // Next-state, grant decode and Moore memory commands; resp pulses follow mem_resp in the same cycle.
  always_comb begin
    w_next      = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_i_resp    = 1'b0;
    w_d_resp    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_read && w_d_req) begin
          w_grant_d = w_pick_d;
          w_grant_i = ~w_pick_d;
        end else begin
          w_grant_i = bus.i_read;
          w_grant_d = w_d_req;
        end
        if (w_grant_d) begin
          w_next = SERVE_D;
        end else if (w_grant_i) begin
          w_next = SERVE_I;
        end
      end
      SERVE_I: begin
        w_mem_read = 1'b1;
        if (bus.mem_resp) begin
          w_i_resp = 1'b1;
          w_next   = IDLE;
        end
      end
      SERVE_D: begin
        w_mem_read  = ~r_op_wr;
        w_mem_write = r_op_wr;
        if (bus.mem_resp) begin
          w_d_resp = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // The owner's address, data and op are captured only on the grant edge, so later requester changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_op_wr  <= 1'b0;
      r_last_d <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant_i) begin
        r_addr   <= bus.i_addr;
        r_last_d <= 1'b0;
      end else if (w_grant_d) begin
        r_addr   <= bus.d_addr;
        r_wdata  <= bus.d_wdata;
        r_op_wr  <= bus.d_write;
        r_last_d <= 1'b1;
      end
    end
  end

  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.i_resp     = w_i_resp;
  assign bus.d_resp     = w_d_resp;
  assign bus.i_rdata    = bus.mem_rdata;
  assign bus.d_rdata    = bus.mem_rdata;
  assign bus.last_grant = r_last_d;

endmodule
